// File: rtl/transmission8_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transmission8_rr_sched_pkg
//  Description : Shared constants and types for the 8-channel round-robin
//                transmission scheduler.
//  Revision    : 1.0  - initial release
// ============================================================================
package transmission8_rr_sched_pkg;

    localparam int NUM_CH = 8;   // channels sharing the distributor
    localparam int SEL_W  = 3;   // width of the channel index (A,B,C)
    localparam int CNT_W  = 4;   // burst counter width, covers MAX_BURST up to 15

    // Scheduler state, encoded with an explicit one-bit width
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage : transmission8_rr_sched_pkg
`default_nettype wire

// File: rtl/transmission8_rr_sched_rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick8
//  Description : Combinational round-robin picker. Rotates the request vector
//                so the pointer channel sits at bit 0, finds the lowest set
//                bit, then adds the pointer back (mod 8) to get the winner.
//  Revision    : 1.0  - initial release
// ============================================================================
module rr_pick8
    import transmission8_rr_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [SEL_W-1:0]  idx_o
);

    logic [NUM_CH-1:0] w_rot;
    logic [SEL_W-1:0]  w_off;

    // Rotate requests so the highest-priority channel lands at bit 0
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_rot[i] = req_i[ptr_i + SEL_W'(i)];
        end
    end

    // Priority-encode the rotated vector: lowest set bit wins
    always_comb begin
        w_off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    assign found_o = |w_rot;
    assign idx_o   = ptr_i + w_off;   // 3-bit sum wraps mod 8

endmodule : rr_pick8
`default_nettype wire

// File: rtl/transmission8_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : transmission8_rr_sched
//  Description : Round-robin scheduler in front of the 8-channel transmission
//                distributor. Grants one channel at a time, bounds each grant
//                to MAX_BURST cycles, and hands off back-to-back on release.
//                All outputs are registered.
//  Revision    : 1.0  - initial release
// ============================================================================
module transmission8_rr_sched
    import transmission8_rr_sched_pkg::*;
#(
    parameter int MAX_BURST = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] iReq,
    output logic [SEL_W-1:0]  oSel,
    output logic [NUM_CH-1:0] oGrant,
    output logic              oBusy,
    output logic              oLast
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              busy_q,  busy_d;
    logic              last_q,  last_d;

    logic [SEL_W-1:0]  w_pick_ptr;
    logic              w_found;
    logic [SEL_W-1:0]  w_idx;

    // While granting, the picker searches from cur+1 so a finishing channel
    // is considered last; when idle it searches from the stored pointer.
    assign w_pick_ptr = (state_q == GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick8 u_pick (
        .req_i   (iReq),
        .ptr_i   (w_pick_ptr),
        .found_o (w_found),
        .idx_o   (w_idx)
    );

    // State, pointer, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    // Next-state: hold, burst-limited extend, or end-and-rearbitrate
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d = GRANT;
                    sel_d   = w_idx;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (iReq[sel_q] && (cnt_q < C_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (w_found) begin
                        sel_d = w_idx;
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs register alongside it
    always_comb begin
        busy_d  = (state_d == GRANT);
        grant_d = busy_d ? (NUM_CH'(1) << sel_d) : '0;
        last_d  = busy_d && (cnt_d == C_MAX);
    end

    assign oSel   = sel_q;
    assign oGrant = grant_q;
    assign oBusy  = busy_q;
    assign oLast  = last_q;

endmodule : transmission8_rr_sched
`default_nettype wire

// File: doc/transmission8_rr_sched.md
Name: transmission8_rr_sched

Overview:
Round-robin scheduler that shares the 8-channel transmission distributor among eight requesters.
- Arbitrates per-channel requests.
- Drives the 3-bit channel select (A,B,C) and a one-hot grant vector.
- Enforces a bounded burst length so no requester monopolises the path.
- Sits directly in front of the 8-bit transmission/distributor datapath.

Parameters:
MAX_BURST, 4, maximum consecutive grant cycles per requester before forced rotation (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
iReq  input  8  request per channel; bit i = channel i wants the path
oSel  output  3  granted channel index; oSel[2]=A, oSel[1]=B, oSel[0]=C
oGrant  output  8  one-hot grant, all-zero when idle
oBusy  output  1  high while a grant is active
oLast  output  1  high in the final permitted burst cycle of the current grant

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, oGrant=0, oSel=0, oBusy=0, oLast=0, pointer=0, burst count=0.
- All outputs are registered. Latency from iReq to grant is 1 cycle.
- Pointer = highest-priority channel. Search order is pointer, pointer+1, ..., pointer+7, all mod 8.
- States: IDLE and GRANT.
- IDLE:
  - iReq==0: stay in IDLE.
  - Otherwise: pick the first set bit in search order, go to GRANT, count=1.
  - oSel holds its previous value while idle. Consumers qualify oSel with oBusy.
- GRANT, current channel cur:
  - Hold: iReq[cur]=1 and count<MAX_BURST → keep grant, count+=1.
  - End: iReq[cur]=0, or count==MAX_BURST → pointer=(cur+1) mod 8, then re-arbitrate in the same edge.
    - Another request pending: hand off back-to-back with no idle cycle. New grant, count=1.
    - Only cur still requesting after expiry: cur is re-granted (it is last in search order) with count=1.
    - No requests: go to IDLE, oGrant=0, oBusy=0.
- oLast = oBusy && count==MAX_BURST.
- MAX_BURST=1 gives strict per-cycle rotation; oLast is high on every grant cycle.
- A request dropping and re-asserting in the same cycle it is evaluated is treated as present. Sampling happens at the edge only.
- Reset mid-grant clears everything immediately, regardless of clock.
- Invariant: popcount(oGrant) ≤ 1 at all times, and oGrant[oSel]==oBusy.
- Count width: 4 bits. Must not wrap, because rotation occurs at count==MAX_BURST.

Decomposition:
- Shared package:
  - NUM_CH=8
  - SEL_W=3
  - state enum {IDLE, GRANT}
  - CNT_W=4
- Sub-module rr_pick8 (combinational):
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - Rotate, priority-encode, add ptr back mod 8.
- Top module holds only the FSM, pointer and counter registers.

Test Plan:
- Reset: hold rst_n=0 with iReq=8'hFF → oGrant=0, oSel=0, oBusy=0, oLast=0. Release → first edge grants ch0 (oGrant=8'h01).
- Single request: iReq=8'h08 held for 10 cycles, MAX_BURST=4 → ch3 granted 1 cycle later and continuously re-granted, count cycling 1..4. oLast pulses every 4th cycle. No idle gap.
- Burst rotation: iReq=8'h28 → ch3 for 4 cycles, then ch5 for 4 cycles, then ch3, with back-to-back handoff. oSel sequence 3,3,3,3,5,5,5,5,3.
- Early release: ch3 granted and iReq drops to 8'h00 at count=2 → next edge oBusy=0, oGrant=0, oSel stays 3. Pointer=4 on the next request of 8'h18 → ch4 granted first.
- Wrap-around: pointer=7, iReq=8'h82 → ch7 granted, then ch1. With all 8 requesting and MAX_BURST=1 → grant order 0,1,...,7,0.
- Reset mid-grant: assert rst_n low asynchronously during a ch5 grant → outputs go to 0 before the next edge. After release with iReq=8'h20 → ch5 re-granted from pointer 0.
